jk_bank_scheduler: RTL and testbench

- Shares one bank of WIDTH JK-type storage cells between NREQ requesters.
- Each requester issues per-bit J/K command words over a valid/ready handshake.
- A round-robin arbiter with optional grant lock picks one command per cycle and registers it.
- The registered command is applied to the bank one cycle later, gated by a downstream apply enable.

---
 rtl/jk_bank_scheduler.sv | 124 ++++++++++++
 tb/tb_jk_bank_scheduler.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jk_bank_scheduler.sv
// Shared bank of WIDTH JK cells fed by NREQ requesters through a round-robin
// arbiter with grant lock and a one-deep command stage gated by apply_en.
module jk_bank_scheduler #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8,
   parameter int IDW   = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ*WIDTH-1:0] req_j,
   input  logic [NREQ*WIDTH-1:0] req_k,
   input  logic [NREQ-1:0]       req_lock,
   input  logic                  apply_en,
   output logic [WIDTH-1:0]      q,
   output logic                  done_valid,
   output logic [IDW-1:0]        done_id,
   output logic [15:0]           apply_cnt
);
   logic [WIDTH-1:0] q_reg;
   logic [WIDTH-1:0] q_next;
   logic [WIDTH-1:0] stage_j_reg;
   logic [WIDTH-1:0] stage_k_reg;
   logic [IDW-1:0]   stage_id_reg;
   logic             stage_valid_reg;
   logic [IDW-1:0]   rr_ptr_reg;
   logic [IDW-1:0]   lock_id_reg;
   logic             lock_active_reg;
   logic             done_valid_reg;
   logic [IDW-1:0]   done_id_reg;
   logic [15:0]      apply_cnt_reg;

   logic             grant_valid;
   logic [IDW-1:0]   grant_id;
   logic [IDW-1:0]   cand;
   logic             can_accept;
   logic             accept;
   logic             apply;
   logic [WIDTH-1:0] j_arr [NREQ];
   logic [WIDTH-1:0] k_arr [NREQ];

   genvar gi;
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_unpack
         assign j_arr[gi] = req_j[gi*WIDTH +: WIDTH];
         assign k_arr[gi] = req_k[gi*WIDTH +: WIDTH];
      end
      // JK characteristic per cell: 00 hold, 01 clear, 10 set, 11 toggle
      for (gi = 0; gi < WIDTH; gi++) begin : g_cell
         assign q_next[gi] = stage_j_reg[gi] ? (stage_k_reg[gi] ? ~q_reg[gi] : 1'b1)
                                             : (stage_k_reg[gi] ? 1'b0 : q_reg[gi]);
      end
   endgenerate

   // A live lock wins; otherwise search upward from the last granted requester.
   always_comb begin
      grant_valid = 1'b0;
      grant_id    = '0;
      cand        = '0;
      if (lock_active_reg && req_valid[lock_id_reg]) begin
         grant_valid = 1'b1;
         grant_id    = lock_id_reg;
      end else begin
         for (int off = 1; off <= NREQ; off++) begin
            cand = IDW'((int'(rr_ptr_reg) + off) % NREQ);
            if (!grant_valid && req_valid[cand]) begin
               grant_valid = 1'b1;
               grant_id    = cand;
            end
         end
      end
   end

   assign can_accept = !stage_valid_reg || apply_en;
   assign apply      = stage_valid_reg && apply_en;
   assign accept     = reset && grant_valid && can_accept;

   always_comb begin
      req_ready = '0;
      if (accept) req_ready[grant_id] = 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         q_reg           <= '0;
         stage_j_reg     <= '0;
         stage_k_reg     <= '0;
         stage_id_reg    <= '0;
         stage_valid_reg <= 1'b0;
         rr_ptr_reg      <= IDW'(NREQ - 1);
         lock_id_reg     <= '0;
         lock_active_reg <= 1'b0;
         done_valid_reg  <= 1'b0;
         done_id_reg     <= '0;
         apply_cnt_reg   <= '0;
      end else begin
         done_valid_reg <= apply;
         if (apply) begin
            q_reg       <= q_next;
            done_id_reg <= stage_id_reg;
            if (apply_cnt_reg != 16'hFFFF) apply_cnt_reg <= apply_cnt_reg + 16'd1;
         end
         if (accept) begin
            stage_j_reg     <= j_arr[grant_id];
            stage_k_reg     <= k_arr[grant_id];
            stage_id_reg    <= grant_id;
            stage_valid_reg <= 1'b1;
            rr_ptr_reg      <= grant_id;
            lock_active_reg <= req_lock[grant_id];
            lock_id_reg     <= grant_id;
         end else begin
            if (apply) stage_valid_reg <= 1'b0;
            // a locked requester that withdraws gives up its lock
            if (lock_active_reg && !req_valid[lock_id_reg]) lock_active_reg <= 1'b0;
         end
      end
   end

   assign q          = q_reg;
   assign done_valid = done_valid_reg;
   assign done_id    = done_id_reg;
   assign apply_cnt  = apply_cnt_reg;
endmodule

// File: tb/tb_jk_bank_scheduler.sv
// Directed scenarios plus a randomized run checked against a behavioural
// model of the arbiter, command stage and JK bank.
module tb_jk_bank_scheduler;
   localparam int NREQ  = 4;
   localparam int WIDTH = 8;
   localparam int IDW   = 2;

   logic                  clk = 1'b0;
   logic                  reset = 1'b0;
   logic [NREQ-1:0]       req_valid;
   logic [NREQ-1:0]       req_ready;
   logic [NREQ*WIDTH-1:0] req_j;
   logic [NREQ*WIDTH-1:0] req_k;
   logic [NREQ-1:0]       req_lock;
   logic                  apply_en;
   logic [WIDTH-1:0]      q;
   logic                  done_valid;
   logic [IDW-1:0]        done_id;
   logic [15:0]           apply_cnt;

   int tests_run = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   jk_bank_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_j(req_j), .req_k(req_k), .req_lock(req_lock), .apply_en(apply_en),
      .q(q), .done_valid(done_valid), .done_id(done_id), .apply_cnt(apply_cnt)
   );

   task automatic idle_inputs();
      req_valid = '0; req_lock = '0; req_j = '0; req_k = '0; apply_en = 1'b1;
   endtask

   task automatic set_req(input int i, input logic v, input logic [WIDTH-1:0] j,
                          input logic [WIDTH-1:0] k, input logic l);
      req_valid[i] = v;
      req_j[i*WIDTH +: WIDTH] = j;
      req_k[i*WIDTH +: WIDTH] = k;
      req_lock[i] = l;
   endtask

   task automatic do_reset();
      @(negedge clk);
      idle_inputs();
      reset = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      req_valid = '1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         tests_run++; if (req_ready !== 4'b0000) begin tests_failed++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
         tests_run++; if (q !== 8'h00) begin tests_failed++; $display("FAIL reset_q got=%h exp=00", q); end
         tests_run++; if (done_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_done got=%b exp=0", done_valid); end
         tests_run++; if (apply_cnt !== 16'h0000) begin tests_failed++; $display("FAIL reset_cnt got=%h exp=0000", apply_cnt); end
      end
      req_valid = '0;
      reset = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         tests_run++; if (req_ready !== 4'b0000) begin tests_failed++; $display("FAIL idle_ready got=%b exp=0000", req_ready); end
         tests_run++; if (q !== 8'h00 || done_valid !== 1'b0 || apply_cnt !== 16'h0000) begin
            tests_failed++; $display("FAIL idle_state got q=%h done=%b cnt=%h exp q=00 done=0 cnt=0000", q, done_valid, apply_cnt);
         end
      end
   endtask

   task automatic test_single_stream();
      logic [WIDTH-1:0] jv [3] = '{8'hF0, 8'h00, 8'hFF};
      logic [WIDTH-1:0] kv [3] = '{8'h00, 8'h30, 8'hFF};
      logic [WIDTH-1:0] qv [3] = '{8'hF0, 8'hC0, 8'h3F};
      for (int b = 0; b < 4; b++) begin
         if (b < 3) begin
            set_req(0, 1'b1, jv[b], kv[b], 1'b0);
            #1;
            tests_run++; if (req_ready !== 4'b0001) begin tests_failed++; $display("FAIL stream_ready beat=%0d got=%b exp=0001", b, req_ready); end
         end else begin
            set_req(0, 1'b0, 8'h00, 8'h00, 1'b0);
         end
         @(posedge clk);
         @(negedge clk);
         if (b >= 1) begin
            $display("[TB] stream apply id=%0d q=%h", done_id, q);
            tests_run++; if (q !== qv[b-1]) begin tests_failed++; $display("FAIL stream_q beat=%0d got=%h exp=%h", b - 1, q, qv[b-1]); end
            tests_run++; if (done_valid !== 1'b1 || done_id !== 2'd0) begin
               tests_failed++; $display("FAIL stream_done beat=%0d got=%b/%0d exp=1/0", b - 1, done_valid, done_id);
            end
         end
      end
      tests_run++; if (apply_cnt !== 16'd3) begin tests_failed++; $display("FAIL stream_cnt got=%0d exp=3", apply_cnt); end
   endtask

   task automatic test_round_robin();
      logic [NREQ-1:0] exp_r;
      do_reset();
      for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 8'h00, 8'h00, 1'b0);
      for (int k = 0; k < 6; k++) begin
         #1;
         exp_r = '0; exp_r[k % NREQ] = 1'b1;
         tests_run++; if (req_ready !== exp_r) begin tests_failed++; $display("FAIL rr_grant cycle=%0d got=%b exp=%b", k, req_ready, exp_r); end
         @(posedge clk);
         @(negedge clk);
         if (k == 0) begin
            tests_run++; if (done_valid !== 1'b0) begin tests_failed++; $display("FAIL rr_first_done got=%b exp=0", done_valid); end
         end else begin
            tests_run++; if (done_valid !== 1'b1 || done_id !== IDW'((k - 1) % NREQ)) begin
               tests_failed++; $display("FAIL rr_done cycle=%0d got=%b/%0d exp=1/%0d", k, done_valid, done_id, (k - 1) % NREQ);
            end
         end
      end
      req_valid = '0;
      @(posedge clk);
      @(negedge clk);
      tests_run++; if (done_id !== 2'd1) begin tests_failed++; $display("FAIL rr_last_done got=%0d exp=1", done_id); end
   endtask

   task automatic test_lock();
      int exp_g [5] = '{2, 2, 2, 2, 3};
      logic [NREQ-1:0] exp_r;
      do_reset();
      set_req(1, 1'b1, 8'h00, 8'h00, 1'b0);
      @(posedge clk);
      @(negedge clk);
      set_req(2, 1'b1, 8'h00, 8'h00, 1'b1);
      set_req(3, 1'b1, 8'h00, 8'h00, 1'b0);
      for (int b = 0; b < 5; b++) begin
         req_lock[2] = (b < 3);
         #1;
         exp_r = '0; exp_r[exp_g[b]] = 1'b1;
         tests_run++; if (req_ready !== exp_r) begin tests_failed++; $display("FAIL lock_grant beat=%0d got=%b exp=%b", b, req_ready, exp_r); end
         @(posedge clk);
         @(negedge clk);
      end
      idle_inputs();
   endtask

   task automatic test_stall();
      do_reset();
      set_req(0, 1'b1, 8'h01, 8'h00, 1'b0);
      @(posedge clk);
      @(negedge clk);
      set_req(0, 1'b0, 8'h00, 8'h00, 1'b0);
      set_req(1, 1'b1, 8'h02, 8'h00, 1'b0);
      apply_en = 1'b0;
      for (int c = 0; c < 5; c++) begin
         #1;
         tests_run++; if (req_ready !== 4'b0000) begin tests_failed++; $display("FAIL stall_ready cycle=%0d got=%b exp=0000", c, req_ready); end
         @(posedge clk);
         @(negedge clk);
         tests_run++; if (q !== 8'h00 || done_valid !== 1'b0 || apply_cnt !== 16'd0) begin
            tests_failed++; $display("FAIL stall_hold cycle=%0d got q=%h done=%b cnt=%0d exp q=00 done=0 cnt=0", c, q, done_valid, apply_cnt);
         end
      end
      apply_en = 1'b1;
      #1;
      tests_run++; if (req_ready !== 4'b0010) begin tests_failed++; $display("FAIL stall_release_ready got=%b exp=0010", req_ready); end
      @(posedge clk);
      @(negedge clk);
      tests_run++; if (q !== 8'h01 || done_valid !== 1'b1 || done_id !== 2'd0) begin
         tests_failed++; $display("FAIL stall_release_apply got q=%h done=%b id=%0d exp q=01 done=1 id=0", q, done_valid, done_id);
      end
      set_req(1, 1'b0, 8'h00, 8'h00, 1'b0);
      @(posedge clk);
      @(negedge clk);
      tests_run++; if (q !== 8'h03 || done_id !== 2'd1 || apply_cnt !== 16'd2) begin
         tests_failed++; $display("FAIL stall_pending_apply got q=%h id=%0d cnt=%0d exp q=03 id=1 cnt=2", q, done_id, apply_cnt);
      end
   endtask

   task automatic test_reset_midstream();
      do_reset();
      set_req(2, 1'b1, 8'hFF, 8'h00, 1'b1);
      @(posedge clk);
      @(negedge clk);
      set_req(2, 1'b1, 8'h0F, 8'h0F, 1'b1);
      @(posedge clk);
      @(negedge clk);
      apply_en = 1'b0;
      tests_run++; if (q !== 8'hFF) begin tests_failed++; $display("FAIL mid_pre_q got=%h exp=FF", q); end
      reset = 1'b0;
      #1;
      tests_run++; if (q !== 8'h00 || done_valid !== 1'b0 || apply_cnt !== 16'd0) begin
         tests_failed++; $display("FAIL mid_async_clear got q=%h done=%b cnt=%0d exp q=00 done=0 cnt=0", q, done_valid, apply_cnt);
      end
      tests_run++; if (req_ready !== 4'b0000) begin tests_failed++; $display("FAIL mid_reset_ready got=%b exp=0000", req_ready); end
      @(negedge clk);
      idle_inputs();
      reset = 1'b1;
      set_req(1, 1'b1, 8'h00, 8'h00, 1'b0);
      set_req(3, 1'b1, 8'h00, 8'h00, 1'b0);
      #1;
      tests_run++; if (req_ready !== 4'b0010) begin tests_failed++; $display("FAIL mid_rr_restart got=%b exp=0010", req_ready); end
      idle_inputs();
      set_req(0, 1'b1, 8'h00, 8'h00, 1'b0);
      set_req(2, 1'b1, 8'h00, 8'h00, 1'b0);
      #1;
      tests_run++; if (req_ready !== 4'b0001) begin tests_failed++; $display("FAIL mid_lock_cleared got=%b exp=0001", req_ready); end
      idle_inputs();
      @(posedge clk);
      @(negedge clk);
      tests_run++; if (done_valid !== 1'b0 || q !== 8'h00 || apply_cnt !== 16'd0) begin
         tests_failed++; $display("FAIL mid_stage_dropped got q=%h done=%b cnt=%0d exp q=00 done=0 cnt=0", q, done_valid, apply_cnt);
      end
   endtask

   task automatic test_saturation();
      do_reset();
      set_req(0, 1'b1, 8'h00, 8'h00, 1'b0);
      for (int c = 1; c <= 65537; c++) begin
         @(posedge clk);
         @(negedge clk);
         if (c - 1 >= 65534) begin
            tests_run++; if (apply_cnt !== ((c - 1 >= 65535) ? 16'hFFFF : 16'hFFFE)) begin
               tests_failed++; $display("FAIL sat_cnt applies=%0d got=%h exp=%h", c - 1, apply_cnt, (c - 1 >= 65535) ? 16'hFFFF : 16'hFFFE);
            end
         end
      end
      idle_inputs();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_random();
      logic [WIDTH-1:0] m_q, m_sj, m_sk;
      logic [15:0]      m_cnt;
      logic             m_full, m_lock, m_done;
      int               m_rr, m_lid, m_sid, m_did, g;
      logic [NREQ-1:0]  exp_r, accepted;
      do_reset();
      m_q = '0; m_sj = '0; m_sk = '0; m_cnt = '0; m_full = 1'b0; m_lock = 1'b0; m_done = 1'b0;
      m_rr = NREQ - 1; m_lid = 0; m_sid = 0; m_did = 0; accepted = '0;
      for (int c = 0; c < 2000; c++) begin
         tests_run++; if (q !== m_q || done_valid !== m_done || apply_cnt !== m_cnt || done_id !== IDW'(m_did)) begin
            tests_failed++; $display("FAIL rand_state cycle=%0d got q=%h done=%b id=%0d cnt=%0d exp q=%h done=%b id=%0d cnt=%0d",
                                     c, q, done_valid, done_id, apply_cnt, m_q, m_done, m_did, m_cnt);
         end
         if (m_done) $display("[TB] rand apply id=%0d q=%h", m_did, m_q);
         for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i] && !accepted[i]) begin
               if ($urandom_range(0, 7) == 0) req_valid[i] = 1'b0;
            end else begin
               set_req(i, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 3) == 0));
            end
         end
         apply_en = ($urandom_range(0, 3) != 0);
         #1;
         g = -1;
         if (m_lock && req_valid[m_lid]) g = m_lid;
         else for (int off = 1; off <= NREQ && g < 0; off++)
            if (req_valid[(m_rr + off) % NREQ]) g = (m_rr + off) % NREQ;
         exp_r = '0;
         if (g >= 0 && (!m_full || apply_en)) exp_r[g] = 1'b1;
         tests_run++; if (req_ready !== exp_r) begin tests_failed++; $display("FAIL rand_ready cycle=%0d got=%b exp=%b", c, req_ready, exp_r); end
         m_done = m_full && apply_en;
         if (m_done) begin
            m_q = (m_sj & ~m_q) | (~m_sk & m_q);
            m_did = m_sid;
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
         end
         if (exp_r != '0) begin
            m_sj = req_j[g*WIDTH +: WIDTH];
            m_sk = req_k[g*WIDTH +: WIDTH];
            m_sid = g; m_full = 1'b1; m_rr = g; m_lock = req_lock[g]; m_lid = g;
         end else begin
            if (m_done) m_full = 1'b0;
            if (m_lock && !req_valid[m_lid]) m_lock = 1'b0;
         end
         accepted = exp_r;
         @(posedge clk);
         @(negedge clk);
      end
      idle_inputs();
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_single_stream();
      test_round_robin();
      test_lock();
      test_stall();
      test_reset_midstream();
      test_saturation();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
